eda_lmax_scan: RTL and testbench

Raster-scan controller and local-maximum classifier for the regional-maximum pipeline. It sits directly downstream of the image RAM. It drives the RAM's center address over every pixel in row-major order and consumes the returned 3x3 window and the neighbour-valid mask. For each pixel it emits a class code on a valid/ready stream that the plateau-resolution stage consumes.

---
 rtl/eda_lmax_pkg.sv | 36 +++
 rtl/eda_lmax_cmp.sv | 46 ++++
 rtl/eda_lmax_scan.sv | 145 ++++++++++++++
 tb/tb_eda_lmax_scan.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eda_lmax_pkg.sv
// rtl/eda_lmax_pkg.sv - shared types and neighbour constants for the local-maximum scan
package eda_lmax_pkg;

    typedef enum logic [1:0] {
        CLS_NOT_MAX    = 2'd0,
        CLS_PLATEAU    = 2'd1,
        CLS_STRICT_MAX = 2'd2
    } lmax_class_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2
    } lmax_state_t;

    // Bit positions in the neighbour-valid mask (shared with the image RAM).
    localparam int NB_UPLEFT    = 7;
    localparam int NB_UP        = 6;
    localparam int NB_UPRIGHT   = 5;
    localparam int NB_LEFT      = 4;
    localparam int NB_RIGHT     = 3;
    localparam int NB_DOWNLEFT  = 2;
    localparam int NB_DOWN      = 1;
    localparam int NB_DOWNRIGHT = 0;
    localparam int NUM_NB       = 8;

    // Pixel slot of the center inside the 9-pixel window, counted from the LSB.
    localparam int CENTER_SLOT  = 4;

    // The window carries the center between left and right, so mask bits at or
    // above the center position sit one pixel slot higher in the window.
    function automatic int nb_slot(input int dir);
        return (dir >= CENTER_SLOT) ? dir + 1 : dir;
    endfunction

endpackage

// File: rtl/eda_lmax_cmp.sv
// rtl/eda_lmax_cmp.sv - combinational 3x3 local-maximum classifier
//   window_i : 9 pixels, MSB first upleft..downright
//   valid_i  : neighbour-inside-image mask, bit7 upleft .. bit0 downright
//   class_o  : NOT_MAX if any valid neighbour is larger, PLATEAU if any equal, else STRICT_MAX
module eda_lmax_cmp
    import eda_lmax_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8
) (
    input  logic [9*PIXEL_WIDTH-1:0] window_i,
    input  logic [7:0]               valid_i,
    output lmax_class_t              class_o
);

    logic [PIXEL_WIDTH-1:0] center;
    logic [PIXEL_WIDTH-1:0] nb;
    logic                   any_gt;
    logic                   any_eq;

    assign center = window_i[CENTER_SLOT*PIXEL_WIDTH +: PIXEL_WIDTH];

    always_comb begin
        nb     = '0;
        any_gt = 1'b0;
        any_eq = 1'b0;
        for (int d = 0; d < NUM_NB; d++) begin
            nb = window_i[nb_slot(d)*PIXEL_WIDTH +: PIXEL_WIDTH];
            // Out-of-image neighbours carry undefined data and are skipped.
            if (valid_i[d]) begin
                if (nb > center) begin
                    any_gt = 1'b1;
                end else if (nb == center) begin
                    any_eq = 1'b1;
                end
            end
        end
        if (any_gt) begin
            class_o = CLS_NOT_MAX;
        end else if (any_eq) begin
            class_o = CLS_PLATEAU;
        end else begin
            class_o = CLS_STRICT_MAX;
        end
    end

endmodule

// File: rtl/eda_lmax_scan.sv
// rtl/eda_lmax_scan.sv - raster-scan controller emitting a class code per pixel
//   start/busy/done          : scan control
//   center_addr              : registered {i, j} to the image RAM
//   window_values/neigh_*    : combinational RAM read data for center_addr
//   out_valid/out_ready/...  : per-pixel result stream (address + class)
//   num_strict/num_plateau   : saturating per-scan statistics
module eda_lmax_scan
    import eda_lmax_pkg::*;
#(
    parameter int M           = 16,
    parameter int N           = 16,
    parameter int PIXEL_WIDTH = 8,
    parameter int J_WIDTH     = $clog2(M),
    parameter int I_WIDTH     = $clog2(N),
    parameter int ADDR_WIDTH  = I_WIDTH + J_WIDTH,
    parameter int CNT_WIDTH   = ADDR_WIDTH + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_WIDTH-1:0]    center_addr,
    input  logic [9*PIXEL_WIDTH-1:0] window_values,
    input  logic [7:0]               neigh_addr_valid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_WIDTH-1:0]    out_addr,
    output logic [1:0]               out_class,
    output logic [CNT_WIDTH-1:0]     num_strict,
    output logic [CNT_WIDTH-1:0]     num_plateau
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};

    lmax_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0]   center_q, center_d;
    logic                    valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]   oaddr_q, oaddr_d;
    lmax_class_t             oclass_q, oclass_d;
    logic [CNT_WIDTH-1:0]    strict_q, strict_d;
    logic [CNT_WIDTH-1:0]    plateau_q, plateau_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    lmax_class_t             cls;
    logic                    slot_free;

    eda_lmax_cmp #(
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_cmp (
        .window_i (window_values),
        .valid_i  (neigh_addr_valid),
        .class_o  (cls)
    );

    assign slot_free = !valid_q || out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            center_q  <= '0;
            valid_q   <= 1'b0;
            oaddr_q   <= '0;
            oclass_q  <= CLS_NOT_MAX;
            strict_q  <= '0;
            plateau_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            center_q  <= center_d;
            valid_q   <= valid_d;
            oaddr_q   <= oaddr_d;
            oclass_q  <= oclass_d;
            strict_q  <= strict_d;
            plateau_q <= plateau_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        center_d  = center_q;
        valid_d   = valid_q;
        oaddr_d   = oaddr_q;
        oclass_d  = oclass_q;
        strict_d  = strict_q;
        plateau_d = plateau_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SCAN;
                    center_d  = '0;
                    strict_d  = '0;
                    plateau_d = '0;
                    busy_d    = 1'b1;
                end
            end
            ST_SCAN: begin
                if (slot_free) begin
                    valid_d  = 1'b1;
                    oaddr_d  = center_q;
                    oclass_d = cls;
                    if (cls == CLS_STRICT_MAX && strict_q != CNT_MAX) begin
                        strict_d = strict_q + CNT_WIDTH'(1);
                    end
                    if (cls == CLS_PLATEAU && plateau_q != CNT_MAX) begin
                        plateau_d = plateau_q + CNT_WIDTH'(1);
                    end
                    // M is a power of two, so a plain increment carries j into i.
                    center_d = center_q + ADDR_WIDTH'(1);
                    if (center_q == LAST_ADDR) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign center_addr = center_q;
    assign out_valid   = valid_q;
    assign out_addr    = oaddr_q;
    assign out_class   = oclass_q;
    assign num_strict  = strict_q;
    assign num_plateau = plateau_q;

endmodule

// File: tb/tb_eda_lmax_scan.sv
// tb/tb_eda_lmax_scan.sv - self-checking bench for eda_lmax_scan
module tb_eda_lmax_scan;
    import eda_lmax_pkg::*;

    localparam int M    = 16;
    localparam int N    = 16;
    localparam int PW   = 8;
    localparam int AW   = 8;
    localparam int CW   = 9;
    localparam int NPIX = M * N;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic            busy;
    logic            done;
    logic [AW-1:0]   center_addr;
    logic [9*PW-1:0] window_values;
    logic [7:0]      neigh_addr_valid;
    logic            out_valid;
    logic            out_ready;
    logic [AW-1:0]   out_addr;
    logic [1:0]      out_class;
    logic [CW-1:0]   num_strict;
    logic [CW-1:0]   num_plateau;

    always #5 clk = ~clk;

    eda_lmax_scan #(.M(M), .N(N), .PIXEL_WIDTH(PW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .center_addr      (center_addr),
        .window_values    (window_values),
        .neigh_addr_valid (neigh_addr_valid),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_addr         (out_addr),
        .out_class        (out_class),
        .num_strict       (num_strict),
        .num_plateau      (num_plateau)
    );

    // Image memory and its combinational read port
    logic [7:0] img [NPIX];
    int         img_gen = 0;

    function automatic bit in_img(input int i, input int j);
        return (i >= 0) && (i < N) && (j >= 0) && (j < M);
    endfunction

    always @(center_addr or img_gen) begin : ram_read
        int ci, cj;
        logic [9*PW-1:0] w;
        logic [7:0] m;
        ci = int'(center_addr[7:4]);
        cj = int'(center_addr[3:0]);
        w = '0;
        m = '0;
        for (int di = -1; di <= 1; di++) begin
            for (int dj = -1; dj <= 1; dj++) begin
                // Outside pixels read as 0xFF so an unmasked compare would show up.
                w = {w[8*PW-1:0], in_img(ci+di, cj+dj) ? img[(ci+di)*M + (cj+dj)] : 8'hFF};
                if (!(di == 0 && dj == 0)) m = {m[6:0], in_img(ci+di, cj+dj)};
            end
        end
        window_values    = w;
        neigh_addr_valid = m;
    end

    // Reference model: class of every pixel from its in-image neighbours
    int exp_cls [NPIX];
    int exp_strict, exp_plateau;

    task automatic build_model();
        exp_strict  = 0;
        exp_plateau = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                bit gt, eq;
                gt = 0;
                eq = 0;
                for (int di = -1; di <= 1; di++) begin
                    for (int dj = -1; dj <= 1; dj++) begin
                        if ((di != 0 || dj != 0) && in_img(i+di, j+dj)) begin
                            if (img[(i+di)*M + (j+dj)] > img[i*M + j]) gt = 1;
                            if (img[(i+di)*M + (j+dj)] == img[i*M + j]) eq = 1;
                        end
                    end
                end
                exp_cls[i*M + j] = gt ? 0 : (eq ? 1 : 2);
                if (!gt && eq) exp_plateau++;
                if (!gt && !eq) exp_strict++;
            end
        end
    endtask

    int asserts = 0;
    int fails   = 0;

    task automatic check(input string name, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Stream checker
    bit            chk_en = 0;
    int            beat_idx;
    int            done_cnt;
    int            got_cls [NPIX];
    bit            stall_prev;
    logic [AW-1:0] st_addr;
    logic [1:0]    st_cls;

    always @(negedge clk) begin
        if (chk_en) begin
            if (stall_prev) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_addr", int'(out_addr), int'(st_addr));
                check("stall_class", int'(out_class), int'(st_cls));
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (beat_idx >= NPIX) begin
                    check("beat_overflow", beat_idx + 1, NPIX);
                end else begin
                    check("beat_addr", int'(out_addr), beat_idx);
                    check("beat_class", int'(out_class), exp_cls[beat_idx]);
                    got_cls[out_addr] = int'(out_class);
                end
                beat_idx++;
            end
            stall_prev = out_valid && !out_ready;
            st_addr    = out_addr;
            st_cls     = out_class;
        end
    end

    // Consumer ready, updated just after each rising edge
    bit rand_ready = 0;
    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    task automatic fill(input logic [7:0] v);
        for (int k = 0; k < NPIX; k++) img[k] = v;
    endtask

    task automatic arm();
        build_model();
        for (int k = 0; k < NPIX; k++) got_cls[k] = -1;
        beat_idx   = 0;
        done_cnt   = 0;
        stall_prev = 0;
        chk_en     = 1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_center_addr"}, int'(center_addr), 0);
        check({tag, "_out_addr"}, int'(out_addr), 0);
        check({tag, "_out_class"}, int'(out_class), 0);
        check({tag, "_num_strict"}, int'(num_strict), 0);
        check({tag, "_num_plateau"}, int'(num_plateau), 0);
    endtask

    task automatic run_scan(input bit rr, input bit restart, output int done_cyc);
        img_gen++;
        arm();
        rand_ready = rr;
        pulse_start();
        done_cyc = -1;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("busy_c1", int'(busy), 1);
                check("center_c1", int'(center_addr), 0);
                check("strict_cleared", int'(num_strict), 0);
                check("plateau_cleared", int'(num_plateau), 0);
            end
            if (restart && c == 100) start = 1'b1;
            if (restart && c == 101) start = 1'b0;
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        if (done_cyc < 0) check("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        chk_en     = 0;
        rand_ready = 0;
        check("beats", beat_idx, NPIX);
        check("done_pulses", done_cnt, 1);
        check("busy_after", int'(busy), 0);
        check("num_strict", int'(num_strict), exp_strict);
        check("num_plateau", int'(num_plateau), exp_plateau);
    endtask

    initial begin
        int dc;
        reset_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        fill(8'h00);
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        reset_n = 1'b1;

        // Flat image
        fill(8'h40);
        run_scan(0, 0, dc);
        check("flat_done_cycle", dc, 258);
        check("flat_plateau_lit", int'(num_plateau), 256);
        check("flat_strict_lit", int'(num_strict), 0);

        // Single peak at {5,7}
        fill(8'h10);
        img[5*M + 7] = 8'hFF;
        run_scan(0, 0, dc);
        check("peak_cls", got_cls[5*M + 7], 2);
        check("peak_nb_ul", got_cls[4*M + 6], 0);
        check("peak_nb_dr", got_cls[6*M + 8], 0);
        check("peak_far", got_cls[0], 1);
        check("peak_strict_lit", int'(num_strict), 1);
        check("peak_plateau_lit", int'(num_plateau), 247);

        // Corner {0,0}
        fill(8'h00);
        img[0] = 8'h80;
        run_scan(0, 0, dc);
        check("c00_cls", got_cls[0], 2);
        check("c00_nb", got_cls[1*M + 1], 0);
        check("c00_plateau_lit", int'(num_plateau), 252);

        // Corner {15,15} sharing its value with {15,14}
        fill(8'h00);
        img[15*M + 15] = 8'h80;
        img[15*M + 14] = 8'h80;
        run_scan(0, 0, dc);
        check("c1515_cls", got_cls[15*M + 15], 1);
        check("c1514_cls", got_cls[15*M + 14], 1);
        check("c1515_strict_lit", int'(num_strict), 0);
        check("c1515_plateau_lit", int'(num_plateau), 252);

        // Ramp with random back-pressure
        for (int i = 0; i < N; i++)
            for (int j = 0; j < M; j++)
                img[i*M + j] = 8'(i + j);
        run_scan(1, 0, dc);
        check("ramp_top_cls", got_cls[15*M + 15], 2);
        check("ramp_strict_lit", int'(num_strict), 1);
        check("ramp_plateau_lit", int'(num_plateau), 0);

        // Second start mid-scan is ignored
        run_scan(0, 1, dc);
        check("restart_done_cycle", dc, 258);

        // Reset in the middle of a scan
        fill(8'h40);
        img_gen++;
        arm();
        pulse_start();
        repeat (50) @(negedge clk);
        chk_en  = 0;
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_done", int'(done), 0);
            check("post_rst_busy", int'(busy), 0);
        end
        run_scan(0, 0, dc);
        check("rescan_done_cycle", dc, 258);
        check("rescan_plateau_lit", int'(num_plateau), 256);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
